// File: rtl/call_initiator.sv
// call_initiator: burst caller over a 4-phase req/ack handshake with echo checking and per-phase timeout
module call_initiator #(
  parameter int DW = 8,
  parameter int CW = 4,
  parameter int TO = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] num_calls,
  input  logic [DW-1:0] base_arg,
  output logic          call_req,
  output logic [DW-1:0] call_arg,
  input  logic          call_ack,
  input  logic [DW-1:0] call_resp,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] mismatch_cnt,
  output logic [DW-1:0] last_resp,
  output logic          timeout
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] ARM  = 3'd1;
  localparam logic [2:0] REQ  = 3'd2;
  localparam logic [2:0] REL  = 3'd3;
  localparam logic [2:0] DONE = 3'd4;
  localparam logic [2:0] TOUT = 3'd5;
  logic [2:0]    st, nx;
  logic [7:0]    pc;
  logic [CW-1:0] num, issued;
  logic          expired;
  assign expired = pc == 8'(TO - 1);
  // next state: each waiting phase leaves on its awaited ack level, else aborts when the phase budget is spent
  always_comb begin
    nx = st;
    case (st)
      IDLE:    nx = !start ? IDLE : num_calls == '0 ? DONE : call_ack ? ARM : REQ;
      ARM:     nx = !call_ack ? REQ : expired ? TOUT : ARM;
      REQ:     nx = call_ack ? REL : expired ? TOUT : REQ;
      REL:     nx = !call_ack ? (issued == num ? DONE : REQ) : expired ? TOUT : REL;
      default: nx = IDLE;
    endcase
  end
  // state, phase counter and outputs registered from the next state so they line up with it
  always_ff @(posedge clk) begin
    if (rst) begin
      st           <= IDLE;
      pc           <= '0;
      num          <= '0;
      issued       <= '0;
      call_req     <= 1'b0;
      call_arg     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      mismatch_cnt <= '0;
      last_resp    <= '0;
      timeout      <= 1'b0;
    end else begin
      st       <= nx;
      pc       <= (nx != st || nx == IDLE) ? '0 : pc + 8'd1;
      call_req <= nx == REQ;
      busy     <= nx != IDLE;
      done     <= nx == DONE || nx == TOUT;
      if (st == IDLE && start) begin
        num          <= num_calls;
        issued       <= '0;
        call_arg     <= base_arg;
        mismatch_cnt <= '0;
        timeout      <= 1'b0;
      end
      if (st == REQ && call_ack) begin
        last_resp <= call_resp;
        issued    <= issued + CW'(1);
        if (call_resp != call_arg && mismatch_cnt != '1)
          mismatch_cnt <= mismatch_cnt + CW'(1);
      end
      if (st == REL && !call_ack && issued != num)
        call_arg <= call_arg + DW'(1);
      if (nx == TOUT)
        timeout <= 1'b1;
    end
  end
endmodule

// File: tb/tb_call_initiator.sv
// tb_call_initiator: directed scenario tests of call_initiator against a behavioural callee
module tb_call_initiator;
  logic       clk = 0, rst = 1, start = 0;
  logic [3:0] num_calls = 0;
  logic [7:0] base_arg = 0;
  logic       call_req, call_ack = 0, busy, done, timeout;
  logic [7:0] call_arg, call_resp = 0, last_resp;
  logic [3:0] mismatch_cnt;
  int checks = 0, errors = 0;
  int done_cnt = 0, req_rises = 0;
  logic auto = 0, xr = 0, req_q = 0;
  int dly = 0, cnt = 0, n = 0;
  logic [7:0] log_arg [0:31];

  call_initiator #(.DW(8), .CW(4), .TO(15)) dut (
    .clk(clk), .rst(rst), .start(start), .num_calls(num_calls), .base_arg(base_arg),
    .call_req(call_req), .call_arg(call_arg), .call_ack(call_ack), .call_resp(call_resp),
    .busy(busy), .done(done), .mismatch_cnt(mismatch_cnt), .last_resp(last_resp), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // callee model: acks after dly cycles, echoes (or XORs 1 into) the argument, logs each argument
  always @(negedge clk) begin
    done_cnt = done_cnt + (done ? 1 : 0);
    req_rises = req_rises + ((call_req && !req_q) ? 1 : 0);
    req_q = call_req;
    if (!auto) cnt = 0;
    else if (call_req && !call_ack) begin
      if (cnt >= dly) begin
        call_ack = 1;
        call_resp = xr ? call_arg ^ 8'h01 : call_arg;
        if (n < 32) log_arg[n] = call_arg;
        n = n + 1;
        cnt = 0;
      end else cnt = cnt + 1;
    end else if (!call_req && call_ack) call_ack = 0;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [3:0] nc, input logic [7:0] ba);
    n = 0;
    num_calls = nc;
    base_arg = ba;
    start = 1;
    cyc();
    start = 0;
  endtask

  task automatic wait_done(input string name);
    bit fin = 0;
    for (int i = 0; i < 400 && !fin; i++) begin
      if (done) fin = 1;
      else cyc();
    end
    checks++;
    if (!fin) begin errors++; $display("FAIL %s: done never seen within 400 cycles", name); end
    cyc();
  endtask

  task automatic test_reset();
    rst = 1;
    cyc(); cyc();
    checks++;
    if ({call_req, busy, done, timeout, mismatch_cnt, call_arg, last_resp} !== 24'd0) begin
      errors++;
      $display("FAIL reset: req=%b busy=%b done=%b to=%b mm=%0d arg=%h lr=%h, all zero required",
               call_req, busy, done, timeout, mismatch_cnt, call_arg, last_resp);
    end
    rst = 0;
    cyc();
  endtask

  task automatic test_echo();
    int d0;
    auto = 1; xr = 0; dly = 1;
    d0 = done_cnt;
    go(4'd3, 8'h10);
    checks++;
    if (call_req !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL echo_latency: req=%b busy=%b, required 1 1", call_req, busy);
    end
    wait_done("echo");
    checks++;
    if (n !== 3 || log_arg[0] !== 8'h10 || log_arg[1] !== 8'h11 || log_arg[2] !== 8'h12) begin
      errors++; $display("FAIL echo_args: n=%0d %h %h %h, required 3 10 11 12", n, log_arg[0], log_arg[1], log_arg[2]);
    end
    checks++;
    if (mismatch_cnt !== 4'd0 || last_resp !== 8'h12 || timeout !== 1'b0) begin
      errors++; $display("FAIL echo_result: mm=%0d lr=%h to=%b, required 0 12 0", mismatch_cnt, last_resp, timeout);
    end
    checks++;
    if (done_cnt - d0 !== 1 || busy !== 1'b0) begin
      errors++; $display("FAIL echo_done: pulses=%0d busy=%b, required 1 0", done_cnt - d0, busy);
    end
  endtask

  task automatic test_mismatch();
    auto = 1; xr = 1; dly = 0;
    go(4'd15, 8'h20);
    wait_done("mm1");
    checks++;
    if (mismatch_cnt !== 4'd15 || last_resp !== 8'h2F) begin
      errors++; $display("FAIL mismatch_15: mm=%0d lr=%h, required 15 2f", mismatch_cnt, last_resp);
    end
    go(4'd15, 8'h30);
    checks++;
    if (mismatch_cnt !== 4'd0) begin
      errors++; $display("FAIL mismatch_clear: mm=%0d, required 0", mismatch_cnt);
    end
    wait_done("mm2");
    checks++;
    if (mismatch_cnt !== 4'd15 || n !== 15) begin
      errors++; $display("FAIL mismatch_sat: mm=%0d calls=%0d, required 15 15", mismatch_cnt, n);
    end
    xr = 0;
  endtask

  task automatic test_wrap();
    auto = 1; dly = 0;
    go(4'd4, 8'hFE);
    wait_done("wrap");
    checks++;
    if (n !== 4 || log_arg[0] !== 8'hFE || log_arg[1] !== 8'hFF || log_arg[2] !== 8'h00 || log_arg[3] !== 8'h01 || mismatch_cnt !== 4'd0) begin
      errors++; $display("FAIL wrap: n=%0d %h %h %h %h mm=%0d, required 4 fe ff 00 01 0",
                         n, log_arg[0], log_arg[1], log_arg[2], log_arg[3], mismatch_cnt);
    end
  endtask

  task automatic test_timeout();
    int hi = 0, d0;
    auto = 0; call_ack = 0;
    d0 = done_cnt;
    go(4'd2, 8'h40);
    for (int i = 0; i < 30; i++) begin
      hi = hi + (call_req ? 1 : 0);
      cyc();
    end
    checks++;
    if (hi !== 15) begin errors++; $display("FAIL timeout_len: req high %0d cycles, required 15", hi); end
    checks++;
    if (timeout !== 1'b1 || busy !== 1'b0 || done_cnt - d0 !== 1) begin
      errors++; $display("FAIL timeout_flag: to=%b busy=%b pulses=%0d, required 1 0 1", timeout, busy, done_cnt - d0);
    end
    auto = 1; dly = 0;
    go(4'd1, 8'h41);
    checks++;
    if (timeout !== 1'b0) begin errors++; $display("FAIL timeout_clear: to=%b, required 0", timeout); end
    wait_done("after_timeout");
  endtask

  task automatic test_arm();
    int r0;
    auto = 0; call_ack = 1;
    r0 = req_rises;
    go(4'd1, 8'h55);
    cyc(); cyc();
    checks++;
    if (call_req !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL arm_hold: req=%b busy=%b, required 0 1", call_req, busy);
    end
    call_ack = 0;
    cyc();
    checks++;
    if (call_req !== 1'b1 || req_rises !== r0) begin
      errors++; $display("FAIL arm_release: req=%b rises=%0d, required 1 %0d", call_req, req_rises, r0);
    end
    auto = 1;
    wait_done("arm");
    checks++;
    if (last_resp !== 8'h55 || timeout !== 1'b0) begin
      errors++; $display("FAIL arm_result: lr=%h to=%b, required 55 0", last_resp, timeout);
    end
  endtask

  task automatic test_zero();
    int r0;
    auto = 1;
    r0 = req_rises;
    go(4'd0, 8'h99);
    checks++;
    if (done !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL zero_done: done=%b busy=%b, required 1 1", done, busy);
    end
    cyc(); cyc();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || req_rises !== r0) begin
      errors++; $display("FAIL zero_after: done=%b busy=%b rises=%0d, required 0 0 %0d", done, busy, req_rises, r0);
    end
  endtask

  task automatic test_rst_mid();
    int d0;
    auto = 0; call_ack = 0;
    go(4'd3, 8'h60);
    cyc(); cyc();
    checks++;
    if (call_req !== 1'b1) begin errors++; $display("FAIL rst_mid_pre: req=%b, required 1", call_req); end
    d0 = done_cnt;
    rst = 1;
    cyc();
    rst = 0;
    checks++;
    if (call_req !== 1'b0 || busy !== 1'b0 || mismatch_cnt !== 4'd0 || done !== 1'b0) begin
      errors++; $display("FAIL rst_mid: req=%b busy=%b mm=%0d done=%b, required 0 0 0 0", call_req, busy, mismatch_cnt, done);
    end
    for (int i = 0; i < 20; i++) cyc();
    checks++;
    if (done_cnt !== d0) begin errors++; $display("FAIL rst_mid_nodone: pulses=%0d, required 0", done_cnt - d0); end
  endtask

  task automatic test_back_to_back();
    auto = 1; dly = 3;
    go(4'd2, 8'h70);
    cyc();
    num_calls = 4'd5; base_arg = 8'h00; start = 1;
    cyc();
    start = 0;
    wait_done("busy_start");
    checks++;
    if (n !== 2 || log_arg[0] !== 8'h70 || log_arg[1] !== 8'h71) begin
      errors++; $display("FAIL busy_start: n=%0d %h %h, required 2 70 71", n, log_arg[0], log_arg[1]);
    end
    dly = 0;
    go(4'd2, 8'hA0);
    wait_done("b2b");
    checks++;
    if (n !== 2 || log_arg[1] !== 8'hA1 || last_resp !== 8'hA1) begin
      errors++; $display("FAIL b2b: n=%0d arg=%h lr=%h, required 2 a1 a1", n, log_arg[1], last_resp);
    end
  endtask

  initial begin
    test_reset();
    test_echo();
    test_mismatch();
    test_wrap();
    test_timeout();
    test_arm();
    test_zero();
    test_rst_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
